// File: rtl/mmio_io_hub_if.sv
// Processor data-port bus seen by the I/O hub: address, write data/enable,
// RAM read data in, gated RAM write enable and read data back to the processor.
interface mmio_io_hub_if;
  // Single-cycle bus: no handshake. A write commits at the clock edge where wren=1;
  // read data (q_dmem) is combinational on the address and is valid in the same cycle.
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_ram;
  logic        ram_wren;
  logic [31:0] q_dmem;

  modport master (
    output address_dmem, data, wren, q_ram,
    input  ram_wren, q_dmem
  );

  modport slave (
    input  address_dmem, data, wren, q_ram,
    output ram_wren, q_dmem
  );
endinterface

// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: decodes button, press-flag, random and LED addresses
// and passes all other accesses through to data RAM.
module mmio_io_hub #(
  parameter int                    NUM_BTN         = 4,
  parameter int                    LED_WIDTH       = 16,
  parameter int                    LFSR_WIDTH      = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS       = LFSR_WIDTH'(16'hB400),
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED       = LFSR_WIDTH'(1),
  parameter int                    RAND_BITS       = 4,
  parameter int                    DEBOUNCE_CYCLES = 4,
  parameter logic [31:0]           BTN_ADDR        = 32'd1000,
  parameter logic [31:0]           PRESS_ADDR      = 32'd1001,
  parameter logic [31:0]           RAND_ADDR       = 32'd2000,
  parameter logic [31:0]           LED_ADDR        = 32'd3000
) (
  input  logic                 clock,
  input  logic                 reset,
  mmio_io_hub_if.slave         bus,
  input  logic [NUM_BTN-1:0]   btn_in,
  output logic [LED_WIDTH-1:0] led_out,
  output logic [RAND_BITS-1:0] rand_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NUM_BTN-1:0]    sync1_q, sync1_d;
  logic [NUM_BTN-1:0]    sync2_q, sync2_d;
  logic [NUM_BTN-1:0]    deb_q, deb_d;
  logic [NUM_BTN-1:0]    press_q, press_d;
  logic [CNT_W-1:0]      cnt_q [NUM_BTN];
  logic [CNT_W-1:0]      cnt_d [NUM_BTN];
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [LED_WIDTH-1:0]  led_q, led_d;

  logic sel_btn, sel_press, sel_rand, sel_led, is_mmio, press_clr;

  assign sel_btn   = (bus.address_dmem == BTN_ADDR);
  assign sel_press = (bus.address_dmem == PRESS_ADDR);
  assign sel_rand  = (bus.address_dmem == RAND_ADDR);
  assign sel_led   = (bus.address_dmem == LED_ADDR);
  assign is_mmio   = sel_btn | sel_press | sel_rand | sel_led;
  assign press_clr = sel_press & ~bus.wren;

  assign bus.ram_wren = bus.wren & ~is_mmio;
  assign bus.q_dmem   = sel_btn   ? 32'(deb_q) :
                        sel_press ? 32'(press_q) :
                        sel_rand  ? 32'(lfsr_q[RAND_BITS-1:0]) :
                        sel_led   ? 32'(led_q) :
                                    bus.q_ram;

  assign led_out  = led_q;
  assign rand_out = lfsr_q[RAND_BITS-1:0];

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      // Any cycle where the sample agrees with the accepted level restarts the count.
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) deb_d[i] = sync2_q[i];
        else                                         cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    // A new debounced rise beats a same-edge read clear.
    press_d = (press_clr ? '0 : press_q) | (deb_d & ~deb_q);
    if (lfsr_q == '0) lfsr_d = LFSR_SEED;
    else              lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    led_d = (bus.wren && sel_led) ? bus.data[LED_WIDTH-1:0] : led_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      press_q <= '0;
      lfsr_q  <= LFSR_SEED;
      led_q   <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      press_q <= press_d;
      lfsr_q  <= lfsr_d;
      led_q   <= led_d;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_mmio_io_hub.sv
// Directed bench for mmio_io_hub: decode, LFSR, debounce, press flags, LED, reset.
module tb_mmio_io_hub;
  localparam logic [31:0] A_BTN   = 32'd1000;
  localparam logic [31:0] A_PRESS = 32'd1001;
  localparam logic [31:0] A_RAND  = 32'd2000;
  localparam logic [31:0] A_LED   = 32'd3000;
  localparam logic [31:0] A_IDLE  = 32'd5;

  logic        clk;
  logic        rst;
  logic [3:0]  btn_in;
  logic [15:0] led_out;
  logic [3:0]  rand_out;
  int          n_checks;
  int          n_fail;

  mmio_io_hub_if bus ();

  mmio_io_hub dut (
    .clock    (clk),
    .reset    (rst),
    .bus      (bus.slave),
    .btn_in   (btn_in),
    .led_out  (led_out),
    .rand_out (rand_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input int n);
    btn_in           = '0;
    bus.wren         = 1'b0;
    bus.data         = '0;
    bus.address_dmem = A_IDLE;
    bus.q_ram        = 32'hDEADBEEF;
    rst              = 1'b1;
    step(n);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(2);
    bus.address_dmem = A_BTN; #1;
    n_checks++;
    if (bus.q_dmem !== 32'd0) begin n_fail++; $display("FAIL reset_btn got=%h exp=%h", bus.q_dmem, 32'd0); end
    bus.address_dmem = A_PRESS; #1;
    n_checks++;
    if (bus.q_dmem !== 32'd0) begin n_fail++; $display("FAIL reset_press got=%h exp=%h", bus.q_dmem, 32'd0); end
    bus.address_dmem = A_LED; #1;
    n_checks++;
    if (bus.q_dmem !== 32'd0) begin n_fail++; $display("FAIL reset_led_rd got=%h exp=%h", bus.q_dmem, 32'd0); end
    bus.address_dmem = A_RAND; #1;
    n_checks++;
    if (bus.q_dmem !== 32'd1) begin n_fail++; $display("FAIL reset_rand got=%h exp=%h", bus.q_dmem, 32'd1); end
    n_checks++;
    if (led_out !== 16'h0000 || rand_out !== 4'h1) begin
      n_fail++; $display("FAIL reset_outs led=%h rand=%h exp led=0000 rand=1", led_out, rand_out);
    end
    bus.address_dmem = A_IDLE; #1;
    n_checks++;
    if (bus.q_dmem !== 32'hDEADBEEF || bus.ram_wren !== 1'b0) begin
      n_fail++; $display("FAIL passthru_rd got=%h wren=%b exp=deadbeef wren=0", bus.q_dmem, bus.ram_wren);
    end
  endtask

  task automatic test_lfsr_seq();
    logic [15:0] exp_s [4];
    exp_s[0] = 16'h0001; exp_s[1] = 16'hB400; exp_s[2] = 16'h5A00; exp_s[3] = 16'h2D00;
    apply_reset(2);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(1);
      n_checks++;
      if (dut.lfsr_q !== exp_s[k] || rand_out !== exp_s[k][3:0]) begin
        n_fail++; $display("FAIL lfsr_seq%0d got=%h rand=%h exp=%h", k, dut.lfsr_q, rand_out, exp_s[k]);
      end
    end
  endtask

  task automatic test_lfsr_period();
    logic [15:0] m;
    int          bad;
    bit          zero_seen;
    apply_reset(2);
    m = 16'h0001; bad = 0; zero_seen = 0;
    for (int k = 0; k < 65535; k++) begin
      step(1);
      m = {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);
      if (dut.lfsr_q !== m) bad++;
      if (dut.lfsr_q == 16'h0000) zero_seen = 1;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL lfsr_walk mismatching_cycles=%0d exp=0", bad); end
    n_checks++;
    if (zero_seen !== 1'b0) begin n_fail++; $display("FAIL lfsr_zero got=%b exp=0", zero_seen); end
    n_checks++;
    if (dut.lfsr_q !== 16'h0001) begin n_fail++; $display("FAIL lfsr_period got=%h exp=0001", dut.lfsr_q); end
  endtask

  task automatic test_debounce();
    logic [3:0] bounce [4];
    bit         bounce_bad;
    bounce[0] = 4'b0100; bounce[1] = 4'b0000; bounce[2] = 4'b0100; bounce[3] = 4'b0000;
    apply_reset(2);
    bounce_bad = 0;
    for (int k = 0; k < 4; k++) begin
      btn_in = bounce[k];
      step(1);
      bus.address_dmem = A_BTN; #1;
      if (bus.q_dmem !== 32'd0) bounce_bad = 1;
      bus.address_dmem = A_IDLE;
    end
    btn_in = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      bus.address_dmem = A_BTN; #1;
      if (bus.q_dmem !== 32'd0) bounce_bad = 1;
      if (k == 5) begin
        n_checks++;
        if (bus.q_dmem !== 32'd0) begin n_fail++; $display("FAIL deb_early got=%h exp=0", bus.q_dmem); end
      end
      bus.address_dmem = A_IDLE;
    end
    n_checks++;
    if (bounce_bad !== 1'b1) begin n_fail++; $display("FAIL deb_rise_seen got=%b exp=1", bounce_bad); end
    bus.address_dmem = A_BTN; #1;
    n_checks++;
    if (bus.q_dmem !== 32'd4) begin n_fail++; $display("FAIL deb_btn got=%h exp=4", bus.q_dmem); end
    bus.address_dmem = A_PRESS; #1;
    n_checks++;
    if (bus.q_dmem !== 32'd4) begin n_fail++; $display("FAIL press_set got=%h exp=4", bus.q_dmem); end
    step(1);
    n_checks++;
    if (bus.q_dmem !== 32'd0) begin n_fail++; $display("FAIL press_clr got=%h exp=0", bus.q_dmem); end
    bus.address_dmem = A_IDLE;
  endtask

  task automatic test_clear_collision();
    apply_reset(2);
    btn_in = 4'b0001;
    step(5);
    bus.address_dmem = A_PRESS; #1;
    n_checks++;
    if (bus.q_dmem !== 32'd0) begin n_fail++; $display("FAIL coll_old got=%h exp=0", bus.q_dmem); end
    step(1);
    n_checks++;
    if (bus.q_dmem !== 32'd1) begin n_fail++; $display("FAIL coll_setwins got=%h exp=1", bus.q_dmem); end
    step(1);
    n_checks++;
    if (bus.q_dmem !== 32'd0) begin n_fail++; $display("FAIL coll_held_clr got=%h exp=0", bus.q_dmem); end
    bus.address_dmem = A_IDLE;
  endtask

  task automatic test_led_write();
    apply_reset(2);
    btn_in = 4'b1000;
    step(6);
    bus.address_dmem = A_LED; bus.data = 32'h0001A5A5; bus.wren = 1'b1; #1;
    n_checks++;
    if (bus.ram_wren !== 1'b0) begin n_fail++; $display("FAIL led_ramwren got=%b exp=0", bus.ram_wren); end
    step(1);
    bus.wren = 1'b0; #1;
    n_checks++;
    if (led_out !== 16'hA5A5 || bus.q_dmem !== 32'h0000A5A5) begin
      n_fail++; $display("FAIL led_load led=%h rd=%h exp led=a5a5 rd=0000a5a5", led_out, bus.q_dmem);
    end
    bus.address_dmem = 32'd20; bus.data = 32'h00001234; bus.wren = 1'b1; #1;
    n_checks++;
    if (bus.ram_wren !== 1'b1) begin n_fail++; $display("FAIL ram_write got=%b exp=1", bus.ram_wren); end
    step(1);
    n_checks++;
    if (led_out !== 16'hA5A5) begin n_fail++; $display("FAIL led_hold got=%h exp=a5a5", led_out); end
    bus.address_dmem = A_PRESS; bus.data = 32'h0000FFFF; #1;
    n_checks++;
    if (bus.ram_wren !== 1'b0) begin n_fail++; $display("FAIL press_wr_ramwren got=%b exp=0", bus.ram_wren); end
    step(1);
    bus.address_dmem = A_RAND; #1;
    n_checks++;
    if (bus.ram_wren !== 1'b0) begin n_fail++; $display("FAIL rand_wr_ramwren got=%b exp=0", bus.ram_wren); end
    step(1);
    bus.wren = 1'b0; bus.address_dmem = A_PRESS; #1;
    n_checks++;
    if (bus.q_dmem !== 32'd8) begin n_fail++; $display("FAIL press_wr_ignored got=%h exp=8", bus.q_dmem); end
    bus.address_dmem = A_IDLE;
  endtask

  task automatic test_mid_reset();
    apply_reset(2);
    bus.address_dmem = A_LED; bus.data = 32'h000000FF; bus.wren = 1'b1;
    step(1);
    bus.wren = 1'b0; bus.address_dmem = A_IDLE;
    btn_in = 4'b0010;
    step(3);
    n_checks++;
    if (led_out !== 16'h00FF) begin n_fail++; $display("FAIL mid_led_pre got=%h exp=00ff", led_out); end
    rst = 1'b1;
    step(1);
    rst = 1'b0; #1;
    n_checks++;
    if (led_out !== 16'h0000 || dut.lfsr_q !== 16'h0001) begin
      n_fail++; $display("FAIL mid_rst led=%h lfsr=%h exp led=0000 lfsr=0001", led_out, dut.lfsr_q);
    end
    bus.address_dmem = A_PRESS; #1;
    n_checks++;
    if (bus.q_dmem !== 32'd0) begin n_fail++; $display("FAIL mid_press0 got=%h exp=0", bus.q_dmem); end
    bus.address_dmem = A_IDLE;
    step(5);
    bus.address_dmem = A_PRESS; #1;
    n_checks++;
    if (bus.q_dmem !== 32'd0) begin n_fail++; $display("FAIL mid_press_early got=%h exp=0", bus.q_dmem); end
    bus.address_dmem = A_IDLE;
    step(1);
    bus.address_dmem = A_PRESS; #1;
    n_checks++;
    if (bus.q_dmem !== 32'd2) begin n_fail++; $display("FAIL mid_press_again got=%h exp=2", bus.q_dmem); end
    bus.address_dmem = A_IDLE;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    test_reset();
    test_lfsr_seq();
    test_debounce();
    test_clear_collision();
    test_led_write();
    test_mid_reset();
    test_lfsr_period();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mmio_io_hub.md
Name: mmio_io_hub

Overview:
Memory-mapped I/O hub between the processor data port and data RAM. Decodes fixed addresses for debounced buttons, sticky button-press flags, an LFSR random source and an LED register, and passes every other address through to RAM. It replaces the ad-hoc address muxing and fixed 4-bit random/button logic with one parametrised block. All logic runs on the processor clock.

Parameters:
NUM_BTN, 4, number of button inputs (1..32)
LED_WIDTH, 16, LED register width (1..32)
LFSR_WIDTH, 16, LFSR state width (2..32)
LFSR_TAPS, 16'hB400, Galois feedback mask, LFSR_WIDTH bits
LFSR_SEED, 1, reset state; must be nonzero
RAND_BITS, 4, low LFSR bits returned on a random read (1..LFSR_WIDTH)
DEBOUNCE_CYCLES, 4, consecutive stable samples needed to accept a button change (>=1)
BTN_ADDR, 1000, read: debounced button levels
PRESS_ADDR, 1001, read: sticky press flags, cleared by the read
RAND_ADDR, 2000, read: random value
LED_ADDR, 3000, read/write: LED register

Ports:
clock  in  1  processor clock
reset  in  1  synchronous, active-high reset
address_dmem  in  32  processor data address
data  in  32  processor write data
wren  in  1  processor write enable
q_ram  in  32  RAM read data
ram_wren  out  1  gated RAM write enable
q_dmem  out  32  read data returned to the processor
btn_in  in  NUM_BTN  raw asynchronous buttons
led_out  out  LED_WIDTH  LED register contents
rand_out  out  RAND_BITS  current random value, for debug and display

Behaviour:
- Reset is synchronous and active-high. It sets sync flops, debounced levels, press flags, debounce counters and the LED register to 0, and sets the LFSR to LFSR_SEED. After reset: led_out=0, rand_out=LFSR_SEED[RAND_BITS-1:0].
- Address decode is a full 32-bit equality compare. is_mmio is asserted for any of the four addresses.
- ram_wren = wren & ~is_mmio. It is combinational, and RAM is never written at an MMIO address.
- q_dmem is combinational on the current address and register state:
  - BTN_ADDR returns the debounced levels, zero-extended.
  - PRESS_ADDR returns the press flags, zero-extended.
  - RAND_ADDR returns the low RAND_BITS of the LFSR, zero-extended.
  - LED_ADDR returns the LED register, zero-extended.
  - Any other address returns q_ram.
- Button path, per button: 2-flop synchronizer, then a debouncer.
  - When the synchronized sample differs from the debounced level, the counter increments. Otherwise the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the sample and the counter clears. A bounce restarts the count.
  - Latency from a stable input change to the debounced level change is 2 + DEBOUNCE_CYCLES cycles.
- Press flags, per bit:
  - Set on a debounced 0->1 transition.
  - Cleared at the clock edge where address_dmem==PRESS_ADDR and wren==0. A held read clears every cycle it is held.
  - Set and clear in the same cycle: set wins, so the bit is 1 afterwards. The read in that cycle returns the pre-edge value.
- LFSR:
  - Galois, right-shift, advances every clock: next = (s>>1) ^ (s[0] ? LFSR_TAPS : 0).
  - If the state is ever all-zero, it reloads LFSR_SEED on the next clock.
  - It is not affected by reads.
- LED register: loads data[LED_WIDTH-1:0] when wren=1 and address==LED_ADDR. led_out is the registered value, one cycle after the write edge.
- Writes to BTN_ADDR, PRESS_ADDR and RAND_ADDR are ignored and have no side effects. They do not clear the press flags.
- Reset asserted mid-debounce or mid-press discards all pending state. Buttons held through reset are seen as a new press once they have debounced after reset.

Test Plan:
- Reset with defaults, then read each MMIO address: BTN=0, PRESS=0, LED=0, RAND=1, led_out=0. Read address 5 with q_ram=32'hDEADBEEF -> q_dmem=32'hDEADBEEF.
- LFSR sequence: state after 0,1,2,3 clocks from reset = 16'h0001, 16'hB400, 16'h5A00, 16'h2D00. Separately run 65535 clocks -> state returns to 16'h0001 and is never 0 on the way.
- Debounce: btn_in[2] toggles 1,0,1 on single cycles, then holds 1 -> the bounce does not change BTN. BTN reads 4 exactly 6 cycles after the stable rise. PRESS reads 4 on the next read, then 0.
- Clear collision: a debounced rise of button 0 on the same edge as a PRESS read clear -> the read returns the old flags, and PRESS=1 afterwards.
- LED write: wren=1, addr=3000, data=32'h0001A5A5 -> led_out=16'hA5A5 next cycle and ram_wren=0. Write to addr 20 -> ram_wren=1 and led_out unchanged. Write 32'hFFFF to addr 1001 -> flags unchanged.
- Mid-operation reset: btn_in[1] held high and the LED set to 16'h00FF, then reset for 1 cycle -> led_out=0, PRESS=0, LFSR=16'h0001. PRESS bit 1 sets again 6 cycles after reset is released.
